// File: rtl/vga_frame_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_frame_renderer
//  Purpose  : Two-stage pixel-colour pipeline for the 640x480 VGA path.
//             Draws the background, the player square and up to N_OBS
//             rectangular obstacles. Game state is latched once per frame
//             so nothing tears mid-frame. The player blinks while paused,
//             and player/obstacle overlap is reported once per frame.
//  Ports    : clk, rst          - pixel clock, async active-high reset
//             pix_valid/x/y     - active-video strobe and coordinates
//             frame_start       - per-frame pulse in vertical blanking
//             gamemode          - 00 init, 01 running, 10 paused, 11 over
//             player_y          - player top edge
//             obstacle_x/y      - packed per-slot {right,left} / {bottom,top}
//             rgb, rgb_valid    - 12-bit colour, qualified 2 cycles later
//             collide           - 1-cycle pulse: previous frame overlapped
//  Revision : 1.0 - initial release
// ============================================================================
module vga_frame_renderer #(
    parameter int N_OBS        = 10,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int PLAYER_X     = 160,
    parameter int PLAYER_SIZE  = 40,
    parameter int UPPER_BOUND  = 20,
    parameter int LOWER_BOUND  = 460,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    input  logic [X_W-1:0]         pix_x,
    input  logic [Y_W-1:0]         pix_y,
    input  logic                   frame_start,
    input  logic [1:0]             gamemode,
    input  logic [Y_W-1:0]         player_y,
    input  logic [N_OBS*2*X_W-1:0] obstacle_x,
    input  logic [N_OBS*2*Y_W-1:0] obstacle_y,
    output logic [11:0]            rgb,
    output logic                   rgb_valid,
    output logic                   collide
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] MODE_INIT   = 2'b00;
    localparam logic [1:0] MODE_RUN    = 2'b01;
    localparam logic [1:0] MODE_PAUSED = 2'b10;
    localparam logic [1:0] MODE_OVER   = 2'b11;

    localparam logic [11:0] COL_BLACK   = 12'h000;
    localparam logic [11:0] COL_GREEN   = 12'h0F0;
    localparam logic [11:0] COL_WHITE   = 12'hFFF;
    localparam logic [11:0] COL_YELLOW  = 12'hFF0;
    localparam logic [11:0] COL_RED     = 12'hF00;
    localparam logic [11:0] COL_MAGENTA = 12'hF0F;
    localparam logic [11:0] COL_BLUE    = 12'h00F;
    localparam logic [11:0] COL_ORANGE  = 12'hF70;

    // Counter must be at least one bit wide even when BLINK_FRAMES is 1.
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // Player extents are compared one bit wider so the right/bottom edge
    // never wraps near the top of the coordinate range.
    localparam logic [X_W:0] PX_LO = (X_W+1)'(PLAYER_X);
    localparam logic [X_W:0] PX_HI = (X_W+1)'(PLAYER_X + PLAYER_SIZE);
    localparam logic [Y_W:0] PSIZE = (Y_W+1)'(PLAYER_SIZE);

    localparam logic [Y_W-1:0] ROW_UB = Y_W'(UPPER_BOUND);
    localparam logic [Y_W-1:0] ROW_LB = Y_W'(LOWER_BOUND);

    // ------------------------------------------------------------------------
    // Per-frame shadow registers and blink state
    // ------------------------------------------------------------------------
    logic [1:0]             shadow_mode;
    logic [Y_W-1:0]         shadow_py;
    logic [N_OBS*2*X_W-1:0] shadow_ox;
    logic [N_OBS*2*Y_W-1:0] shadow_oy;
    logic                   shadow_phase;
    logic [CNT_W-1:0]       blink_cnt;
    logic                   blink_phase;

    // The frame being latched renders with the blink phase as it stood
    // before this pulse advances it. A pause therefore always opens with
    // BLINK_FRAMES visible frames, then alternates in BLINK_FRAMES halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_mode  <= MODE_INIT;
            shadow_py    <= '0;
            shadow_ox    <= '0;
            shadow_oy    <= '0;
            shadow_phase <= 1'b1;
            blink_cnt    <= '0;
            blink_phase  <= 1'b1;
        end else if (frame_start) begin
            shadow_mode  <= gamemode;
            shadow_py    <= player_y;
            shadow_ox    <= obstacle_x;
            shadow_oy    <= obstacle_y;
            shadow_phase <= blink_phase;
            if (gamemode != MODE_PAUSED) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (blink_cnt == CNT_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1 hit detection (combinational on the incoming pixel)
    // ------------------------------------------------------------------------
    logic [Y_W:0]     py_end;
    logic             player_hit;
    logic [N_OBS-1:0] slot_hit;

    always_comb begin
        py_end     = {1'b0, shadow_py} + PSIZE;
        player_hit = ({1'b0, pix_x} >= PX_LO) && ({1'b0, pix_x} < PX_HI) &&
                     (pix_y >= shadow_py) && ({1'b0, pix_y} < py_end);
    end

    for (genvar i = 0; i < N_OBS; i++) begin : g_slot
        logic [X_W-1:0] left;
        logic [X_W-1:0] right;
        logic [Y_W-1:0] top;
        logic [Y_W-1:0] bottom;
        logic           enabled;

        always_comb begin
            left        = shadow_ox[i*2*X_W +: X_W];
            right       = shadow_ox[i*2*X_W+X_W +: X_W];
            top         = shadow_oy[i*2*Y_W +: Y_W];
            bottom      = shadow_oy[i*2*Y_W+Y_W +: Y_W];
            // Empty or inverted rectangles are treated as unused slots.
            enabled     = (left < right) && (top < bottom);
            slot_hit[i] = enabled &&
                          (pix_x >= left) && (pix_x < right) &&
                          (pix_y >= top)  && (pix_y < bottom);
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1 registers. Mode and blink phase travel with the pixel so a
    // pixel accepted alongside frame_start still renders with the old frame.
    // ------------------------------------------------------------------------
    logic             s1_valid;
    logic [Y_W-1:0]   s1_y;
    logic             s1_player_hit;
    logic [N_OBS-1:0] s1_obs_hit;
    logic [1:0]       s1_mode;
    logic             s1_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_y          <= '0;
            s1_player_hit <= 1'b0;
            s1_obs_hit    <= '0;
            s1_mode       <= MODE_INIT;
            s1_phase      <= 1'b1;
        end else begin
            s1_valid      <= pix_valid;
            s1_y          <= pix_y;
            s1_player_hit <= player_hit;
            s1_obs_hit    <= slot_hit;
            s1_mode       <= shadow_mode;
            s1_phase      <= shadow_phase;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 colour selection
    // ------------------------------------------------------------------------
    logic        in_bounds;
    logic        obs_any;
    logic        player_shown;
    logic        overlap;
    logic        hit_now;
    logic [11:0] bg_colour;
    logic [11:0] colour_next;

    always_comb begin
        in_bounds    = (s1_y > ROW_UB) && (s1_y < ROW_LB);
        obs_any      = |s1_obs_hit;
        player_shown = s1_player_hit && ((s1_mode != MODE_PAUSED) || s1_phase);
        overlap      = in_bounds && player_shown && obs_any;
        hit_now      = s1_valid && overlap &&
                       ((s1_mode == MODE_RUN) || (s1_mode == MODE_PAUSED));
    end

    always_comb begin
        bg_colour = COL_GREEN;
        case (s1_mode)
            MODE_INIT:   bg_colour = COL_GREEN;
            MODE_RUN:    bg_colour = COL_WHITE;
            MODE_PAUSED: bg_colour = COL_YELLOW;
            MODE_OVER:   bg_colour = COL_RED;
            default:     bg_colour = COL_GREEN;
        endcase
    end

    always_comb begin
        colour_next = bg_colour;
        if (!in_bounds) begin
            colour_next = COL_BLACK;
        end else if (s1_mode == MODE_INIT) begin
            colour_next = bg_colour;
        end else if (player_shown && obs_any) begin
            colour_next = COL_MAGENTA;
        end else if (player_shown) begin
            colour_next = COL_BLUE;
        end else if (obs_any) begin
            colour_next = COL_ORANGE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb       <= COL_BLACK;
            rgb_valid <= 1'b0;
        end else begin
            rgb       <= s1_valid ? colour_next : COL_BLACK;
            rgb_valid <= s1_valid;
        end
    end

    // ------------------------------------------------------------------------
    // Collision accumulator. frame_start never coincides with a valid
    // stage-1 pixel, so the clear taking priority loses nothing.
    // ------------------------------------------------------------------------
    logic hit_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_acc <= 1'b0;
            collide <= 1'b0;
        end else if (frame_start) begin
            collide <= hit_acc;
            hit_acc <= 1'b0;
        end else begin
            collide <= 1'b0;
            if (hit_now) begin
                hit_acc <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_frame_renderer
//  Purpose  : Self-checking bench for vga_frame_renderer. Directed steps plus
//             randomized frames compared against a behavioural model of the
//             frame renderer (rectangles, priorities, blink schedule).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_renderer;

    localparam int N_OBS = 10;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int PX    = 160;
    localparam int PS    = 40;
    localparam int UB    = 20;
    localparam int LB    = 460;
    localparam int BF    = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   pix_valid;
    logic [X_W-1:0]         pix_x;
    logic [Y_W-1:0]         pix_y;
    logic                   frame_start;
    logic [1:0]             gamemode;
    logic [Y_W-1:0]         player_y;
    logic [N_OBS*2*X_W-1:0] obstacle_x;
    logic [N_OBS*2*Y_W-1:0] obstacle_y;
    logic [11:0]            rgb;
    logic                   rgb_valid;
    logic                   collide;

    vga_frame_renderer #(
        .N_OBS(N_OBS), .X_W(X_W), .Y_W(Y_W), .PLAYER_X(PX), .PLAYER_SIZE(PS),
        .UPPER_BOUND(UB), .LOWER_BOUND(LB), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .frame_start(frame_start), .gamemode(gamemode),
        .player_y(player_y), .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
        .rgb(rgb), .rgb_valid(rgb_valid), .collide(collide)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Values presented on the game-state inputs
    int in_mode, in_py;
    int in_l[N_OBS], in_r[N_OBS], in_t[N_OBS], in_b[N_OBS];
    // Model of what the renderer latched for the current frame
    int m_mode, m_py;
    int m_l[N_OBS], m_r[N_OBS], m_t[N_OBS], m_b[N_OBS];
    bit m_vis;
    int paused_idx;
    bit m_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_pixel(input int x, input int y,
                                        output logic [11:0] col, output bit ovl);
        bit inb, ph, oh, vis;
        logic [11:0] bg;
        inb = (y > UB) && (y < LB);
        ph  = (x >= PX) && (x < PX + PS) && (y >= m_py) && (y < m_py + PS);
        oh  = 1'b0;
        for (int i = 0; i < N_OBS; i++)
            if (m_l[i] < m_r[i] && m_t[i] < m_b[i] &&
                x >= m_l[i] && x < m_r[i] && y >= m_t[i] && y < m_b[i])
                oh = 1'b1;
        case (m_mode)
            0: bg = 12'h0F0;
            1: bg = 12'hFFF;
            2: bg = 12'hFF0;
            default: bg = 12'hF00;
        endcase
        vis = (m_mode != 2) || m_vis;
        ovl = inb && ph && vis && oh && (m_mode == 1 || m_mode == 2);
        if (!inb)            col = 12'h000;
        else if (m_mode == 0) col = bg;
        else if (ph && vis && oh) col = 12'hF0F;
        else if (ph && vis)  col = 12'h00F;
        else if (oh)         col = 12'hF70;
        else                 col = bg;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_py = 0; m_vis = 1'b1; paused_idx = 0; m_acc = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            m_l[i] = 0; m_r[i] = 0; m_t[i] = 0; m_b[i] = 0;
        end
    endtask

    task automatic drive_inputs();
        gamemode = 2'(in_mode);
        player_y = Y_W'(in_py);
        for (int i = 0; i < N_OBS; i++) begin
            obstacle_x[i*2*X_W +: X_W]     = X_W'(in_l[i]);
            obstacle_x[i*2*X_W+X_W +: X_W] = X_W'(in_r[i]);
            obstacle_y[i*2*Y_W +: Y_W]     = Y_W'(in_t[i]);
            obstacle_y[i*2*Y_W+Y_W +: Y_W] = Y_W'(in_b[i]);
        end
    endtask

    // One frame_start pulse; collide must reflect the frame just finished.
    task automatic pulse_frame(input string tag);
        bit exp_col;
        @(negedge clk);
        drive_inputs();
        frame_start = 1'b1;
        exp_col = m_acc;
        m_acc   = 1'b0;
        m_mode  = in_mode;
        m_py    = in_py;
        for (int i = 0; i < N_OBS; i++) begin
            m_l[i] = in_l[i]; m_r[i] = in_r[i]; m_t[i] = in_t[i]; m_b[i] = in_b[i];
        end
        if (in_mode == 2) begin
            m_vis = ((paused_idx / BF) % 2) == 0;
            paused_idx++;
        end else begin
            m_vis = 1'b1;
            paused_idx = 0;
        end
        @(negedge clk);
        frame_start = 1'b0;
        check({tag, "_collide"}, 32'(collide), 32'(exp_col));
        @(negedge clk);
        check({tag, "_collide_end"}, 32'(collide), 32'd0);
    endtask

    // Single pixel; req < 0 means take the colour from the model.
    task automatic send_pixel(input string tag, input int x, input int y, input int req);
        logic [11:0] col;
        bit ovl;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_x = X_W'(x);
        pix_y = Y_W'(y);
        model_pixel(x, y, col, ovl);
        if (ovl) m_acc = 1'b1;
        if (req >= 0) col = 12'(req);
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        check(tag, {19'd0, rgb_valid, rgb}, {19'd0, 1'b1, col});
    endtask

    // Back-to-back random pixels with occasional bubbles.
    task automatic stream(input string tag, input int n);
        logic [12:0] q[$];
        logic [12:0] exp;
        logic [11:0] col;
        bit ovl;
        int x, y;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                exp = q.pop_front();
                check(tag, {19'd0, rgb_valid, rgb}, {19'd0, exp});
            end
            if (i < n && $urandom_range(0, 7) != 0) begin
                x = ($urandom_range(0, 1) == 1) ? $urandom_range(120, 240) : $urandom_range(0, 639);
                y = $urandom_range(0, 479);
                pix_valid = 1'b1;
                pix_x = X_W'(x);
                pix_y = Y_W'(y);
                model_pixel(x, y, col, ovl);
                if (ovl) m_acc = 1'b1;
                q.push_back({1'b1, col});
            end else begin
                pix_valid = 1'b0;
                q.push_back(13'd0);
            end
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; frame_start = 1'b0;
        in_mode = 0; in_py = 0;
        for (int i = 0; i < N_OBS; i++) begin
            in_l[i] = 0; in_r[i] = 0; in_t[i] = 0; in_b[i] = 0;
        end
        drive_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_rgb", 32'(rgb), 32'h000);
        check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
        check("reset_collide", 32'(collide), 32'd0);
        rst = 1'b0;
        send_pixel("reset_mode00_bg", 300, 200, 12'h0F0);

        // Running, all slots empty, row boundaries
        in_mode = 1;
        pulse_frame("run_empty");
        send_pixel("run_bg", 300, 200, 12'hFFF);
        send_pixel("row_top_black", 300, 10, 12'h000);
        send_pixel("row_bot_black", 300, 470, 12'h000);
        send_pixel("row_ub_edge", 300, 20, 12'h000);
        send_pixel("row_ub_in", 300, 21, 12'hFFF);
        send_pixel("row_lb_in", 300, 459, 12'hFFF);
        send_pixel("row_lb_edge", 300, 460, 12'h000);

        // Player and one obstacle
        in_py = 100;
        in_l[0] = 150; in_r[0] = 180; in_t[0] = 120; in_b[0] = 130;
        pulse_frame("geom");
        send_pixel("both_hit", 170, 125, 12'hF0F);
        send_pixel("player_only", 190, 125, 12'h00F);
        send_pixel("obs_only", 155, 125, 12'hF70);
        send_pixel("player_right_in", 199, 125, 12'h00F);
        send_pixel("player_right_out", 200, 125, 12'hFFF);
        send_pixel("player_bottom_in", 170, 139, 12'h00F);
        send_pixel("player_bottom_out", 170, 140, 12'hFFF);
        send_pixel("player_top_out", 170, 99, 12'hFFF);
        pulse_frame("collide_pulse");

        // Geometry changes between pulses must not show up
        in_l[0] = 400; in_r[0] = 420;
        @(negedge clk);
        drive_inputs();
        send_pixel("midframe_old_empty", 410, 125, 12'hFFF);
        send_pixel("midframe_old_hit", 170, 125, 12'hF0F);
        pulse_frame("midframe");
        send_pixel("newframe_obs", 410, 125, 12'hF70);
        send_pixel("newframe_player", 170, 125, 12'h00F);

        // Pause blinking
        in_mode = 2;
        in_l[0] = 150; in_r[0] = 180;
        for (int k = 0; k < 6; k++) begin
            pulse_frame("pause");
            send_pixel("blink_player", 170, 110, (((k / BF) % 2) == 0) ? 12'h00F : 12'hFF0);
            send_pixel("blink_overlap", 170, 125, -1);
        end
        in_mode = 1;
        pulse_frame("pause_exit");

        // Init mode hides everything and never collides
        in_mode = 0;
        pulse_frame("init");
        send_pixel("init_overlap", 170, 125, 12'h0F0);
        send_pixel("init_bg", 300, 200, 12'h0F0);
        send_pixel("init_oob", 300, 10, 12'h000);
        pulse_frame("init_nocollide");

        // Degenerate slots are never drawn
        in_mode = 1;
        in_l[1] = 200; in_r[1] = 200; in_t[1] = 200; in_b[1] = 200;
        in_l[2] = 300; in_r[2] = 250; in_t[2] = 0;   in_b[2] = 400;
        in_l[3] = 500; in_r[3] = 520; in_t[3] = 300; in_b[3] = 300;
        pulse_frame("degen");
        send_pixel("degen_point", 200, 200, 12'hFFF);
        send_pixel("degen_inverted", 270, 300, 12'hFFF);
        send_pixel("degen_inverted_l", 299, 100, 12'hFFF);
        send_pixel("degen_flat", 510, 300, 12'hFFF);

        // Reset in the middle of a frame drops the in-flight pixel
        @(negedge clk);
        pix_valid = 1'b1; pix_x = 10'd300; pix_y = 9'd200;
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_valid", 32'(rgb_valid), 32'd0);
        check("midrst_rgb", 32'(rgb), 32'h000);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid_after", 32'(rgb_valid), 32'd0);
        send_pixel("midrst_shadow_cleared", 300, 200, 12'h0F0);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            in_mode = $urandom_range(0, 3);
            in_py   = $urandom_range(0, 479);
            in_l[0] = $urandom_range(100, 220);
            in_r[0] = in_l[0] + $urandom_range(0, 80);
            in_t[0] = (in_py + $urandom_range(0, 30) > 470) ? 470 : in_py + $urandom_range(0, 30);
            in_b[0] = in_t[0] + $urandom_range(0, 40);
            for (int i = 1; i < N_OBS; i++) begin
                in_l[i] = $urandom_range(0, 639);
                in_r[i] = $urandom_range(0, 639);
                in_t[i] = $urandom_range(0, 479);
                in_b[i] = $urandom_range(0, 479);
            end
            pulse_frame("rand_frame");
            stream("rand_pixel", 150);
        end
        pulse_frame("rand_last");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
